// File: rtl/qspinor_io.sv
// Byte-level QSPI NOR lane engine: TX/RX/dummy phases of 2*N clk cycles (N=8/4/2) plus one resp cycle.
// Requests are taken only in IDLE; tx/rx starts are gated by txq_rdy/rxq_rdy, with no stalling mid-operation.
module qspinor_io (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] width,
    input  logic       tx_req,
    input  logic       txq_rdy,
    input  logic [7:0] txq_d,
    output logic       tx_resp,
    input  logic       rx_req,
    input  logic       rxq_rdy,
    output logic [7:0] rxq_d,
    output logic       rx_resp,
    input  logic       dmy_req,
    input  logic       dmy_dir,
    input  logic [3:0] dmy_pattern_out,
    output logic       dmy_resp,
    output logic       qspi_sclk,
    output logic [3:0] qspi_dir,
    output logic [3:0] qspi_mosi,
    input  logic [3:0] qspi_miso
);
    typedef enum logic [1:0] {IDLE, TX, RX, DMY} state_t;

    state_t     state;
    logic [1:0] wl;
    logic       dir_l;
    logic [7:0] sreg;
    logic [3:0] cnt;
    logic [1:0] wnorm;

    // wl encoding: 0 = 1-bit, 1 = 2-bit, 2 = 4-bit
    assign wnorm = (width == 2'd3) ? 2'd2 : width;

    function automatic logic [3:0] chunk(input logic [7:0] b, input logic [1:0] w);
        case (w)
            2'd0:    chunk = {3'b000, b[7]};
            2'd1:    chunk = {2'b00, b[7:6]};
            default: chunk = b[7:4];
        endcase
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] b, input logic [1:0] w);
        case (w)
            2'd0:    shift_out = {b[6:0], 1'b0};
            2'd1:    shift_out = {b[5:0], 2'b00};
            default: shift_out = {b[3:0], 4'h0};
        endcase
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic [1:0] w,
                                             input logic [3:0] m);
        case (w)
            2'd0:    shift_in = {b[6:0], m[1]};
            2'd1:    shift_in = {b[5:0], m[1:0]};
            default: shift_in = {b[3:0], m};
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] w);
        case (w)
            2'd0:    lane_mask = 4'h1;
            2'd1:    lane_mask = 4'h3;
            default: lane_mask = 4'hF;
        endcase
    endfunction

    // Index of the final sclk-high cycle: 2*N-1
    function automatic logic [3:0] last_cnt(input logic [1:0] w);
        case (w)
            2'd0:    last_cnt = 4'd15;
            2'd1:    last_cnt = 4'd7;
            default: last_cnt = 4'd3;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wl        <= 2'd0;
            dir_l     <= 1'b0;
            sreg      <= 8'h00;
            cnt       <= 4'd0;
            qspi_sclk <= 1'b0;
            qspi_dir  <= 4'h0;
            qspi_mosi <= 4'h0;
            rxq_d     <= 8'h00;
            tx_resp   <= 1'b0;
            rx_resp   <= 1'b0;
            dmy_resp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    wl  <= wnorm;
                    if (tx_req && txq_rdy) begin
                        state     <= TX;
                        sreg      <= txq_d;
                        qspi_dir  <= lane_mask(wnorm);
                        qspi_mosi <= chunk(txq_d, wnorm);
                    end else if (rx_req && rxq_rdy) begin
                        state    <= RX;
                        sreg     <= 8'h00;
                        qspi_dir <= 4'h0;
                    end else if (dmy_req) begin
                        state     <= DMY;
                        dir_l     <= dmy_dir;
                        qspi_dir  <= dmy_dir ? 4'h0 : 4'hF;
                        qspi_mosi <= dmy_dir ? 4'h0 : dmy_pattern_out;
                    end
                end
                default: begin
                    if (tx_resp || rx_resp || dmy_resp) begin
                        tx_resp  <= 1'b0;
                        rx_resp  <= 1'b0;
                        dmy_resp <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == last_cnt(wl)) begin
                        qspi_sclk <= 1'b0;
                        qspi_dir  <= 4'h0;
                        qspi_mosi <= 4'h0;
                        tx_resp   <= (state == TX);
                        rx_resp   <= (state == RX);
                        dmy_resp  <= (state == DMY);
                        if (state == RX)
                            rxq_d <= sreg;
                    end else begin
                        cnt       <= cnt + 4'd1;
                        qspi_sclk <= ~qspi_sclk;
                        if (!qspi_sclk) begin
                            // This edge raises sclk: the flash data is sampled here
                            if (state == RX)
                                sreg <= shift_in(sreg, wl, qspi_miso);
                        end else if (state == TX) begin
                            sreg      <= shift_out(sreg, wl);
                            qspi_mosi <= chunk(shift_out(sreg, wl), wl);
                        end
                        if (state == DMY)
                            qspi_mosi <= dir_l ? 4'h0 : dmy_pattern_out;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qspinor_io.sv
// Bench for qspinor_io: per-cycle behavioural model plus directed literal scenarios and random traffic.
module tb_qspinor_io;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] width;
    logic       tx_req, txq_rdy, rx_req, rxq_rdy, dmy_req, dmy_dir;
    logic [7:0] txq_d;
    logic [3:0] dmy_pattern_out, qspi_miso;
    logic       tx_resp, rx_resp, dmy_resp, qspi_sclk;
    logic [7:0] rxq_d;
    logic [3:0] qspi_dir, qspi_mosi;

    always #5 clk = ~clk;

    qspinor_io dut (
        .clk(clk), .rst(rst), .width(width),
        .tx_req(tx_req), .txq_rdy(txq_rdy), .txq_d(txq_d), .tx_resp(tx_resp),
        .rx_req(rx_req), .rxq_rdy(rxq_rdy), .rxq_d(rxq_d), .rx_resp(rx_resp),
        .dmy_req(dmy_req), .dmy_dir(dmy_dir), .dmy_pattern_out(dmy_pattern_out),
        .dmy_resp(dmy_resp), .qspi_sclk(qspi_sclk), .qspi_dir(qspi_dir),
        .qspi_mosi(qspi_mosi), .qspi_miso(qspi_miso)
    );

    int tests = 0;
    int fails = 0;

    // Model: an operation is a sequence of 2N cycles (k even: sclk low, odd: high) then one resp cycle
    int busy = 0, op = 0, k = 0, n = 0, w = 1, mbyte = 0, ddir = 0, racc = 0, erx = 0;

    // Observation helpers for directed scenarios
    logic [3:0] cap_mosi[$];
    logic [3:0] cap_dir[$];
    int  ntx = 0, nrx = 0, ndmy = 0, ndir_nz = 0, cyc_no = 0, resp_cyc = 0;
    logic prev_sclk = 1'b0;
    int  use_tbl = 0;
    logic [3:0] rx_tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        int esclk, edir, emosi, etx, erxr, edmy;
        @(posedge clk);
        cyc_no++;
        if (rst) begin
            busy = 0;
            erx  = 0;
        end else if (busy != 0) begin
            if (k == 2 * n) begin
                busy = 0;
            end else begin
                if (op == 1 && k % 2 == 0)
                    racc = ((racc << w) | (w == 1 ? int'(qspi_miso[1])
                                                  : (int'(qspi_miso) & ((1 << w) - 1)))) & 255;
                k++;
                if (k == 2 * n && op == 1)
                    erx = racc;
            end
        end else if ((tx_req && txq_rdy) || (rx_req && rxq_rdy) || dmy_req) begin
            busy  = 1;
            k     = 0;
            racc  = 0;
            w     = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
            n     = 8 / w;
            op    = (tx_req && txq_rdy) ? 0 : (rx_req && rxq_rdy) ? 1 : 2;
            mbyte = int'(txq_d);
            ddir  = int'(dmy_dir);
        end
        esclk = 0; edir = 0; emosi = 0; etx = 0; erxr = 0; edmy = 0;
        if (busy != 0) begin
            if (k == 2 * n) begin
                etx  = (op == 0) ? 1 : 0;
                erxr = (op == 1) ? 1 : 0;
                edmy = (op == 2) ? 1 : 0;
            end else begin
                esclk = k % 2;
                if (op == 0) begin
                    edir  = (1 << w) - 1;
                    emosi = (mbyte >> (8 - w * (k / 2 + 1))) & ((1 << w) - 1);
                end else if (op == 2 && ddir == 0) begin
                    edir  = 15;
                    emosi = int'(dmy_pattern_out);
                end
            end
        end
        #1;
        chk("sclk", qspi_sclk, esclk);
        chk("dir", qspi_dir, edir);
        chk("mosi", qspi_mosi, emosi);
        chk("tx_resp", tx_resp, etx);
        chk("rx_resp", rx_resp, erxr);
        chk("dmy_resp", dmy_resp, edmy);
        chk("rxq_d", rxq_d, erx);
        if (!prev_sclk && qspi_sclk) begin
            cap_mosi.push_back(qspi_mosi);
            cap_dir.push_back(qspi_dir);
        end
        prev_sclk = qspi_sclk;
        if (tx_resp) begin ntx++; resp_cyc = cyc_no; end
        if (rx_resp) begin nrx++; resp_cyc = cyc_no; end
        if (dmy_resp) begin ndmy++; resp_cyc = cyc_no; end
        if (qspi_dir != 4'h0) ndir_nz++;
        @(negedge clk);
        tx_req  = 1'b0;
        rx_req  = 1'b0;
        dmy_req = 1'b0;
        if (use_tbl != 0)
            qspi_miso = rx_tbl[cap_mosi.size() < 4 ? cap_mosi.size() : 3];
        else
            qspi_miso = 4'($urandom);
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) cyc();
    endtask

    task automatic clear_obs();
        cap_mosi.delete();
        cap_dir.delete();
        ntx = 0; nrx = 0; ndmy = 0; ndir_nz = 0; resp_cyc = 0;
    endtask

    initial begin
        logic [3:0] e34 [8];
        int acc_cyc;
        e34 = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
        rx_tbl = '{4'h1, 4'h2, 4'h3, 4'h0};
        rst = 1'b1; width = 2'd0; tx_req = 0; txq_rdy = 1; txq_d = 8'h00;
        rx_req = 0; rxq_rdy = 1; dmy_req = 0; dmy_dir = 0; dmy_pattern_out = 4'h0;
        qspi_miso = 4'h0;
        run(2);
        chk("reset_outputs", {qspi_sclk, qspi_dir, qspi_mosi, rxq_d, tx_resp, rx_resp, dmy_resp}, 0);
        rst = 1'b0;
        run(2);

        // 1-bit TX of 0x5A
        clear_obs();
        width = 2'd0; txq_d = 8'h5A; tx_req = 1;
        run(20);
        chk("tx1_rises", cap_mosi.size(), 8);
        for (int i = 0; i < 8 && i < cap_mosi.size(); i++) begin
            chk("tx1_mosi0", cap_mosi[i][0], e34[i]);
            chk("tx1_dir", cap_dir[i], 4'h1);
        end
        chk("tx1_resp_count", ntx, 1);

        // 4-bit TX of 0x5A with latency
        clear_obs();
        width = 2'd2; txq_d = 8'h5A; tx_req = 1;
        acc_cyc = cyc_no + 1;
        run(10);
        chk("tx4_rises", cap_mosi.size(), 2);
        if (cap_mosi.size() == 2) begin
            chk("tx4_mosi_hi", cap_mosi[0], 4'h5);
            chk("tx4_mosi_lo", cap_mosi[1], 4'hA);
            chk("tx4_dir", cap_dir[0], 4'hF);
        end
        chk("tx4_resp_count", ntx, 1);
        chk("tx4_latency", resp_cyc - acc_cyc, 4);

        // 2-bit RX sampling 1,2,3,0 per rise
        clear_obs();
        use_tbl = 1; qspi_miso = rx_tbl[0];
        width = 2'd1; rx_req = 1;
        run(12);
        use_tbl = 0;
        chk("rx2_rxq_d", rxq_d, 8'h6C);
        chk("rx2_resp_count", nrx, 1);
        chk("rx2_dir_zero", ndir_nz, 0);
        run(3);
        chk("rx2_rxq_held", rxq_d, 8'h6C);

        // Dummy phases, driven then released
        clear_obs();
        width = 2'd0; dmy_dir = 0; dmy_pattern_out = 4'hC; dmy_req = 1;
        run(20);
        chk("dmy_out_rises", cap_mosi.size(), 8);
        for (int i = 0; i < cap_mosi.size(); i++) begin
            chk("dmy_out_mosi", cap_mosi[i], 4'hC);
            chk("dmy_out_dir", cap_dir[i], 4'hF);
        end
        chk("dmy_out_resp", ndmy, 1);
        clear_obs();
        dmy_dir = 1; dmy_req = 1;
        run(20);
        chk("dmy_in_rises", cap_mosi.size(), 8);
        chk("dmy_in_dir_zero", ndir_nz, 0);
        chk("dmy_in_resp", ndmy, 1);

        // Priority and ignored requests
        clear_obs();
        width = 2'd2; txq_d = 8'h3C; tx_req = 1; rx_req = 1;
        run(2);
        rx_req = 1;
        run(8);
        chk("prio_tx_count", ntx, 1);
        chk("prio_rx_count", nrx, 0);
        clear_obs();
        rxq_rdy = 0; rx_req = 1;
        run(20);
        chk("rx_noroom_rises", cap_mosi.size(), 0);
        chk("rx_noroom_resp", nrx, 0);
        rxq_rdy = 1;

        // Reset in the middle of a TX
        clear_obs();
        width = 2'd0; txq_d = 8'hFF; tx_req = 1;
        run(5);
        rst = 1'b1;
        #1;
        chk("midrst_async", {qspi_sclk, qspi_dir, qspi_mosi}, 0);
        run(2);
        rst = 1'b0;
        run(25);
        chk("midrst_no_resp", ntx, 0);
        clear_obs();
        width = 2'd2; txq_d = 8'hA5; tx_req = 1;
        run(8);
        chk("postrst_resp", ntx, 1);
        if (cap_mosi.size() == 2) chk("postrst_mosi", {cap_mosi[0], cap_mosi[1]}, 8'hA5);
        else chk("postrst_rises", cap_mosi.size(), 2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            width           = 2'($urandom);
            txq_rdy         = ($urandom % 4) != 0;
            rxq_rdy         = ($urandom % 4) != 0;
            txq_d           = 8'($urandom);
            dmy_dir         = 1'($urandom);
            dmy_pattern_out = 4'($urandom);
            tx_req          = ($urandom % 6) == 0;
            rx_req          = ($urandom % 6) == 0;
            dmy_req         = ($urandom % 6) == 0;
            if (tx_req && !txq_rdy) begin rx_req = 0; dmy_req = 0; end
            if (rx_req && !rxq_rdy) dmy_req = 0;
            rst = ($urandom % 400) == 0;
            cyc();
        end
        rst = 1'b0;
        run(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
